ir_frame_receiver: RTL and testbench
====================================

IR_FRAME_RECEIVER -- requirements
Module: ir_frame_receiver

Interface
REQ-001 SHALL have parameter BASE_PULSE_WIDTH, default 30000, meaning the base unit T in clk cycles.
REQ-002 SHALL have parameter TOL_PCT, default 10, meaning the integer timing tolerance in percent (0..49).
REQ-003 SHALL have parameter MAX_BITS, default 20, meaning the data register width and the longest frame (1..31).
REQ-004 SHALL have parameter ACCEPT_MASK, 32 bits, default bits 12, 15 and 20 set, meaning bit n set accepts an n-bit frame.
REQ-005 SHALL have port clk, input, 1 bit, the single clock, all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port ir, input, 1 bit, asynchronous demodulated IR; low = carrier present, high = idle.
REQ-008 SHALL have port out_data, output, MAX_BITS bits, the received frame, frame bit k at out_data[k], unused MSBs 0.
REQ-009 SHALL have port out_len, output, 5 bits, the number of bits in out_data.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning out_data/out_len hold an unconsumed frame.
REQ-011 SHALL have port out_ready, input, 1 bit, the consumer accept; transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a frame aborted after a valid start.
REQ-013 SHALL have port overrun, output, 1 bit, a one-cycle pulse when a good frame is dropped.

Function
REQ-014 SHALL pass ir through a 2-flop synchronizer (reset value 1); the decoder uses only the synchronized value s_ir.
REQ-015 SHALL use limits MIN1=BASE*(100-TOL_PCT)/100 and MAX1=BASE*(100+TOL_PCT)/100 (integer, truncating); MINk=k*MIN1 and MAXk=k*MAX1.
REQ-016 SHALL size the counter cnt as clog2(MAX4+2) bits; cnt saturates at all-ones and never wraps.
REQ-017 SHALL have states IDLE, START, PAUSE, BIT and WAIT_HIGH.
REQ-018 IDLE: on s_ir=0 go to START with cnt<=1; otherwise stay.
REQ-019 START, s_ir=0: increment cnt; if cnt>MAX4, go to WAIT_HIGH with no error.
REQ-020 START, s_ir=1: if MIN4<=cnt<=MAX4, go to PAUSE with cnt<=1 and nbits<=0 and clear the shift data; else go to IDLE with no error.
REQ-021 PAUSE, s_ir=1: increment cnt; if cnt>MAX2, end of frame (REQ-024).
REQ-022 PAUSE, s_ir=0: if MIN1<=cnt<=MAX1, go to BIT with cnt<=1; else pulse frame_err and go to WAIT_HIGH.
REQ-023 BIT, s_ir=1: if MIN1<=cnt<=MAX1, store bit 0 at index nbits; if MIN2<=cnt<=MAX2, store bit 1; then nbits+1 and go to PAUSE with cnt<=1.
- Other width: pulse frame_err and go to IDLE.
- Storing when nbits==MAX_BITS: pulse frame_err and go to IDLE.
- BIT, s_ir=0: increment cnt; cnt>MAX2 pulses frame_err and goes to WAIT_HIGH.
REQ-024 End of frame SHALL go to IDLE and take exactly one of three actions:
- ACCEPT_MASK[nbits]=0 (including nbits=0): pulse frame_err.
- Accepted and output slot free (out_valid=0, or out_valid and out_ready this cycle): load out_data/out_len and set out_valid next cycle.
- Accepted and slot occupied with out_ready=0: keep the old frame and pulse overrun.
REQ-025 WAIT_HIGH: go to IDLE on the first s_ir=1 cycle.
REQ-026 out_valid SHALL clear on transfer unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
REQ-027 out_data/out_len SHALL be stable while out_valid=1 and not transferred.
REQ-028 Latency SHALL be: out_valid rises 1 cycle after the end-of-frame cycle, i.e. MAX2+1 synchronized-high cycles after the last bit's rising edge, plus 2 synchronizer cycles.
REQ-029 frame_err and overrun SHALL be registered, high for exactly one cycle, and never asserted together.

Reset
REQ-030 While rst_n=0: state=IDLE, cnt=0, nbits=0, shift data=0, synchronizer=11, out_data=0, out_len=0, out_valid=0, frame_err=0, overrun=0.
REQ-031 Reset mid-frame or with out_valid=1 SHALL discard everything; after release the first IDLE low starts fresh.

Verification (BASE=10, TOL_PCT=10, so MIN1=9, MAX1=11)
REQ-032 Input 40 low; 12 bits 0xA5C LSB-first (10 low for 0, 20 low for 1, 10-high pauses); then high -> out_valid=1, out_data=0x00A5C, out_len=12, no error.
REQ-033 Same start, 15 bits then 20 bits (all ones), with out_ready=1 -> two transfers, out_len 15 then 20, out_data 0x07FFF then 0xFFFFF.
REQ-034 Start 36, 44, 35, 45, 60 low -> first two decode, 35/45 silently ignored, 60 goes to WAIT_HIGH; frame_err never pulses.
REQ-035 A valid 12-bit frame with one bit 15 low -> frame_err one cycle, no out_valid; a 13-bit frame -> frame_err at end of frame.
REQ-036 Two frames with out_ready=0 -> first frame retained, overrun one cycle; then a frame ending in the same cycle out_ready=1 -> out_valid stays 1 with the new data.
REQ-037 rst_n low during bit 6, release, then a full 12-bit frame -> only the second frame is reported.

Source files
------------

// File: rtl/ir_frame_receiver.sv
// Pulse-width IR frame decoder: 4T start, T pauses, T/2T bits,
// frame ends on a long high; one-deep valid/ready output slot.
module ir_frame_receiver #(
  parameter int          BASE_PULSE_WIDTH = 30000,
  parameter int          TOL_PCT          = 10,
  parameter int          MAX_BITS         = 20,
  parameter logic [31:0] ACCEPT_MASK      = 32'h0010_9000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ir,
  output logic [MAX_BITS-1:0] out_data,
  output logic [4:0]          out_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic                overrun
);

  localparam int MIN1 = BASE_PULSE_WIDTH * (100 - TOL_PCT) / 100;
  localparam int MAX1 = BASE_PULSE_WIDTH * (100 + TOL_PCT) / 100;
  localparam int CNT_W = $clog2(4 * MAX1 + 2);

  localparam logic [CNT_W-1:0] C_MIN1 = CNT_W'(MIN1);
  localparam logic [CNT_W-1:0] C_MAX1 = CNT_W'(MAX1);
  localparam logic [CNT_W-1:0] C_MIN2 = CNT_W'(2 * MIN1);
  localparam logic [CNT_W-1:0] C_MAX2 = CNT_W'(2 * MAX1);
  localparam logic [CNT_W-1:0] C_MIN4 = CNT_W'(4 * MIN1);
  localparam logic [CNT_W-1:0] C_MAX4 = CNT_W'(4 * MAX1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PAUSE,
    S_BIT,
    S_WAIT
  } state_t;

  logic [1:0]          r_sync;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [4:0]          r_nbits;
  logic [MAX_BITS-1:0] r_shift;
  logic [MAX_BITS-1:0] r_data;
  logic [4:0]          r_len;
  logic                r_valid;
  logic                r_err;
  logic                r_ovr;

  state_t              w_state_n;
  logic [CNT_W-1:0]    w_cnt_n;
  logic [4:0]          w_nbits_n;
  logic [MAX_BITS-1:0] w_shift_n;
  logic                w_err;
  logic                w_ovr;
  logic                w_load;

  logic                w_s_ir;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_in1;
  logic                w_in2;
  logic                w_in4;
  logic                w_slot;
  logic [MAX_BITS-1:0] w_one;

  assign w_s_ir    = r_sync[1];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + C_ONE;
  assign w_in1     = (r_cnt >= C_MIN1) && (r_cnt <= C_MAX1);
  assign w_in2     = (r_cnt >= C_MIN2) && (r_cnt <= C_MAX2);
  assign w_in4     = (r_cnt >= C_MIN4) && (r_cnt <= C_MAX4);
  assign w_slot    = !r_valid || out_ready;
  assign w_one     = MAX_BITS'(1) << r_nbits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], ir};
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_nbits_n = r_nbits;
    w_shift_n = r_shift;
    w_err     = 1'b0;
    w_ovr     = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_s_ir) begin
          w_state_n = S_START;
          w_cnt_n   = C_ONE;
        end
      end
      S_START: begin
        if (!w_s_ir) begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc > C_MAX4) w_state_n = S_WAIT;
        end else if (w_in4) begin
          w_state_n = S_PAUSE;
          w_cnt_n   = C_ONE;
          w_nbits_n = 5'd0;
          w_shift_n = '0;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (w_s_ir) begin
          w_cnt_n = w_cnt_inc;
          // a pause longer than 2T closes the frame
          if (w_cnt_inc > C_MAX2) begin
            w_state_n = S_IDLE;
            if (!ACCEPT_MASK[r_nbits]) w_err = 1'b1;
            else if (w_slot)           w_load = 1'b1;
            else                       w_ovr = 1'b1;
          end
        end else if (w_in1) begin
          w_state_n = S_BIT;
          w_cnt_n   = C_ONE;
        end else begin
          w_err     = 1'b1;
          w_state_n = S_WAIT;
        end
      end
      S_BIT: begin
        if (!w_s_ir) begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc > C_MAX2) begin
            w_err     = 1'b1;
            w_state_n = S_WAIT;
          end
        end else if (!(w_in1 || w_in2)) begin
          w_err     = 1'b1;
          w_state_n = S_IDLE;
        end else if (r_nbits == 5'(MAX_BITS)) begin
          w_err     = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          if (!w_in1) w_shift_n = r_shift | w_one;
          w_nbits_n = r_nbits + 5'd1;
          w_cnt_n   = C_ONE;
          w_state_n = S_PAUSE;
        end
      end
      S_WAIT: begin
        if (w_s_ir) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_nbits <= 5'd0;
      r_shift <= '0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_nbits <= w_nbits_n;
      r_shift <= w_shift_n;
      r_err   <= w_err;
      r_ovr   <= w_ovr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_len   <= 5'd0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_shift;
      r_len   <= r_nbits;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_len   = r_len;
  assign out_valid = r_valid;
  assign frame_err = r_err;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Directed bench for ir_frame_receiver with T=10 cycles, 10% tolerance.
// Inputs move 2 time units after posedge; outputs are sampled there too.
module tb_ir_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir = 1'b1;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic [4:0]  out_len;
  logic        out_valid;
  logic        frame_err;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int n_err = 0;
  int n_ovr = 0;
  int n_both = 0;
  logic [19:0] q_data[$];
  logic [4:0]  q_len[$];

  always #5 clk = ~clk;

  ir_frame_receiver #(
    .BASE_PULSE_WIDTH(10),
    .TOL_PCT(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ir(ir),
    .out_data(out_data),
    .out_len(out_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always @(negedge clk) begin
    if (frame_err) n_err++;
    if (overrun) n_ovr++;
    if (frame_err && overrun) n_both++;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_len.push_back(out_len);
    end
  end

  task automatic hold(input logic v, input int n);
    ir = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tx(input logic [31:0] d, input int nb,
                    input int start, input int bad_idx,
                    input int tail);
    hold(1'b0, start);
    for (int i = 0; i < nb; i++) begin
      hold(1'b1, 10);
      if (i == bad_idx) hold(1'b0, 15);
      else hold(1'b0, d[i] ? 20 : 10);
    end
    hold(1'b1, tail);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    total++;
    if (out_data !== 20'h0) begin
      bad++;
      $display("FAIL rst_data: got %h want 0", out_data);
    end
    total++;
    if (out_len !== 5'd0) begin
      bad++;
      $display("FAIL rst_len: got %0d want 0", out_len);
    end
    total++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL rst_pulses: got %b%b want 00",
               frame_err, overrun);
    end
    rst_n = 1'b1;
    hold(1'b1, 5);
  endtask

  task automatic test_single;
    int e0;
    e0 = n_err;
    out_ready = 1'b0;
    q_data.delete();
    q_len.delete();
    tx(32'hA5C, 12, 40, -1, 24);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early: got %b want 0", out_valid);
    end
    hold(1'b1, 1);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_valid: got %b want 1", out_valid);
    end
    hold(1'b1, 5);
    total++;
    if (out_data !== 20'h00A5C || out_len !== 5'd12) begin
      bad++;
      $display("FAIL single_data: got %h/%0d want 00a5c/12",
               out_data, out_len);
    end
    total++;
    if (n_err - e0 !== 0) begin
      bad++;
      $display("FAIL single_err: got %0d want 0", n_err - e0);
    end
    out_ready = 1'b1;
    hold(1'b1, 1);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_consume: got %b want 0", out_valid);
    end
    total++;
    if (q_data.size() !== 1) begin
      bad++;
      $display("FAIL single_xfers: got %0d want 1", q_data.size());
    end
  endtask

  task automatic test_stream;
    int e0;
    e0 = n_err;
    out_ready = 1'b1;
    q_data.delete();
    q_len.delete();
    tx(32'h7FFF, 15, 40, -1, 40);
    tx(32'hFFFFF, 20, 40, -1, 40);
    out_ready = 1'b0;
    total++;
    if (q_data.size() !== 2) begin
      bad++;
      $display("FAIL stream_xfers: got %0d want 2", q_data.size());
    end else begin
      total++;
      if (q_data[0] !== 20'h07FFF || q_len[0] !== 5'd15) begin
        bad++;
        $display("FAIL stream_first: got %h/%0d want 07fff/15",
                 q_data[0], q_len[0]);
      end
      total++;
      if (q_data[1] !== 20'hFFFFF || q_len[1] !== 5'd20) begin
        bad++;
        $display("FAIL stream_second: got %h/%0d want fffff/20",
                 q_data[1], q_len[1]);
      end
    end
    total++;
    if (out_valid !== 1'b0 || n_err - e0 !== 0) begin
      bad++;
      $display("FAIL stream_end: got v=%b e=%0d want v=0 e=0",
               out_valid, n_err - e0);
    end
  endtask

  task automatic test_start_tol;
    int e0;
    e0 = n_err;
    out_ready = 1'b1;
    q_data.delete();
    q_len.delete();
    tx(32'hA5C, 12, 36, -1, 40);
    tx(32'h5A3, 12, 44, -1, 40);
    hold(1'b0, 35);
    hold(1'b1, 40);
    hold(1'b0, 45);
    hold(1'b1, 40);
    hold(1'b0, 60);
    hold(1'b1, 40);
    tx(32'hF0F, 12, 40, -1, 40);
    out_ready = 1'b0;
    total++;
    if (q_data.size() !== 3) begin
      bad++;
      $display("FAIL tol_xfers: got %0d want 3", q_data.size());
    end else begin
      total++;
      if (q_data[0] !== 20'h00A5C || q_len[0] !== 5'd12) begin
        bad++;
        $display("FAIL tol_36: got %h/%0d want 00a5c/12",
                 q_data[0], q_len[0]);
      end
      total++;
      if (q_data[1] !== 20'h005A3 || q_len[1] !== 5'd12) begin
        bad++;
        $display("FAIL tol_44: got %h/%0d want 005a3/12",
                 q_data[1], q_len[1]);
      end
      total++;
      if (q_data[2] !== 20'h00F0F) begin
        bad++;
        $display("FAIL tol_recover: got %h want 00f0f", q_data[2]);
      end
    end
    total++;
    if (n_err - e0 !== 0) begin
      bad++;
      $display("FAIL tol_err: got %0d want 0", n_err - e0);
    end
  endtask

  task automatic test_errors;
    int e0;
    out_ready = 1'b1;
    q_data.delete();
    q_len.delete();
    e0 = n_err;
    tx(32'hA5C, 12, 40, 5, 40);
    total++;
    if (n_err - e0 !== 1) begin
      bad++;
      $display("FAIL err_width: got %0d want 1", n_err - e0);
    end
    e0 = n_err;
    tx(32'h1ABC, 13, 40, -1, 40);
    total++;
    if (n_err - e0 !== 1) begin
      bad++;
      $display("FAIL err_len13: got %0d want 1", n_err - e0);
    end
    e0 = n_err;
    tx(32'h1FFFFF, 21, 40, -1, 40);
    total++;
    if (n_err - e0 !== 1) begin
      bad++;
      $display("FAIL err_len21: got %0d want 1", n_err - e0);
    end
    e0 = n_err;
    hold(1'b0, 40);
    hold(1'b1, 40);
    total++;
    if (n_err - e0 !== 1) begin
      bad++;
      $display("FAIL err_len0: got %0d want 1", n_err - e0);
    end
    out_ready = 1'b0;
    total++;
    if (q_data.size() !== 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_noframe: got %0d/%b want 0/0",
               q_data.size(), out_valid);
    end
    total++;
    if (n_both !== 0) begin
      bad++;
      $display("FAIL err_both: got %0d want 0", n_both);
    end
  endtask

  task automatic test_overrun;
    int e0;
    int o0;
    e0 = n_err;
    o0 = n_ovr;
    out_ready = 1'b0;
    q_data.delete();
    q_len.delete();
    tx(32'h123, 12, 40, -1, 40);
    tx(32'h456, 12, 40, -1, 40);
    total++;
    if (out_valid !== 1'b1 || out_data !== 20'h00123) begin
      bad++;
      $display("FAIL ovr_keep: got %b/%h want 1/00123",
               out_valid, out_data);
    end
    total++;
    if (n_ovr - o0 !== 1 || n_err - e0 !== 0) begin
      bad++;
      $display("FAIL ovr_pulse: got o=%0d e=%0d want o=1 e=0",
               n_ovr - o0, n_err - e0);
    end
    tx(32'h5A5A, 15, 40, -1, 24);
    out_ready = 1'b1;
    hold(1'b1, 1);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 20'h05A5A ||
        out_len !== 5'd15) begin
      bad++;
      $display("FAIL ovr_swap: got %b/%h/%0d want 1/05a5a/15",
               out_valid, out_data, out_len);
    end
    total++;
    if (q_data.size() !== 1 || n_ovr - o0 !== 1) begin
      bad++;
      $display("FAIL ovr_xfer: got %0d/%0d want 1/1",
               q_data.size(), n_ovr - o0);
    end else begin
      total++;
      if (q_data[0] !== 20'h00123) begin
        bad++;
        $display("FAIL ovr_old: got %h want 00123", q_data[0]);
      end
    end
    out_ready = 1'b1;
    hold(1'b1, 1);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovr_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int e0;
    out_ready = 1'b0;
    tx(32'h0F0, 12, 40, -1, 40);
    hold(1'b0, 40);
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    hold(1'b1, 10);
    hold(1'b0, 5);
    rst_n = 1'b0;
    hold(1'b1, 3);
    total++;
    if (out_valid !== 1'b0 || out_data !== 20'h0 ||
        out_len !== 5'd0) begin
      bad++;
      $display("FAIL mid_rst: got %b/%h/%0d want 0/0/0",
               out_valid, out_data, out_len);
    end
    rst_n = 1'b1;
    hold(1'b1, 5);
    e0 = n_err;
    tx(32'hA5C, 12, 40, -1, 40);
    total++;
    if (out_valid !== 1'b1 || out_data !== 20'h00A5C ||
        out_len !== 5'd12) begin
      bad++;
      $display("FAIL mid_frame: got %b/%h/%0d want 1/00a5c/12",
               out_valid, out_data, out_len);
    end
    total++;
    if (n_err - e0 !== 0) begin
      bad++;
      $display("FAIL mid_err: got %0d want 0", n_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_start_tol();
    test_errors();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
